// File: rtl/line_prefetcher.sv
// Purpose: ping-pong prefetch of framebuffer lines into a two-bank line buffer ahead of VGA scanout.
// Latency: one line fill takes H_PIXELS+READ_LATENCY cycles; underrun pulses one cycle after the offending line end.
// Backpressure: none upstream; fills park in WAIT until the display frees a bank, and the display never stalls.
// Ports: system_clock/reset_n; enable, frame_start, line_finished (vga-domain level), fb_base control inputs;
//        fb_read_address/fb_read_data framebuffer read port; line_write_address/data/enable line-buffer port;
//        display_bank, busy, underrun status outputs.
module line_prefetcher #(
    parameter int PIXEL_WIDTH        = 12,
    parameter int FB_ADDRESS_WIDTH   = 22,
    parameter int LINE_ADDRESS_WIDTH = 13,
    parameter int H_PIXELS           = 640,
    parameter int SRC_LINES          = 240,
    parameter int LINE_REPEAT        = 2,
    parameter int READ_LATENCY       = 1
) (
    input  logic                          system_clock,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          frame_start,
    input  logic                          line_finished,
    input  logic [FB_ADDRESS_WIDTH-1:0]   fb_base,
    output logic [FB_ADDRESS_WIDTH-1:0]   fb_read_address,
    input  logic [PIXEL_WIDTH-1:0]        fb_read_data,
    output logic [LINE_ADDRESS_WIDTH-1:0] line_write_address,
    output logic [PIXEL_WIDTH-1:0]        line_write_data,
    output logic                          line_write_enable,
    output logic                          display_bank,
    output logic                          busy,
    output logic                          underrun
);
    localparam int IDX_W  = $clog2(H_PIXELS);
    localparam int CNT_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = $clog2(SRC_LINES + 1);
    localparam int REP_W  = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} state_t;

    state_t                      state;
    logic [FB_ADDRESS_WIDTH-1:0] src_addr;
    logic [LINE_W-1:0]           src_line;
    logic [CNT_W-1:0]            issue_cnt;
    logic                        write_bank;
    logic [1:0]                  bank_valid;
    logic [REP_W-1:0]            repeat_cnt;
    logic [READ_LATENCY-1:0]     pipe_vld;
    logic [IDX_W-1:0]            pipe_idx [READ_LATENCY];
    logic [2:0]                  line_sync;

    logic       issue;
    logic       wr_fire;
    logic       fill_done;
    logic       line_end;
    logic       le_active;
    logic       switch_disp;
    logic       new_disp;
    logic [1:0] bv_filled;
    logic [1:0] bv_next;
    logic [LINE_ADDRESS_WIDTH-1:0] wr_base;

    // Two flops synchronise the vga-domain level, the third gives the rising-edge reference.
    assign line_end  = line_sync[1] & ~line_sync[2];
    assign le_active = line_end && (state != IDLE);

    assign issue = (state == FILL) && (issue_cnt < CNT_W'(H_PIXELS));

    // A write returning on a restart or disable cycle belongs to the abandoned fill and is dropped.
    assign wr_fire   = pipe_vld[READ_LATENCY-1] && enable && !frame_start;
    assign fill_done = wr_fire && (pipe_idx[READ_LATENCY-1] == IDX_W'(H_PIXELS - 1));

    assign switch_disp = le_active && (repeat_cnt == REP_W'(LINE_REPEAT - 1));
    assign new_disp    = ~display_bank;

    // Bank bookkeeping for this cycle: a completing fill marks its bank valid first, so the
    // underrun check sees it; a display switch then frees the bank being left, so the FILL/WAIT
    // decisions see the freed bank in the same cycle.
    always_comb begin
        bv_filled = bank_valid;
        if (fill_done) begin
            bv_filled[write_bank] = 1'b1;
        end
        bv_next = bv_filled;
        if (switch_disp) begin
            bv_next[display_bank] = 1'b0;
        end
    end

    assign wr_base = write_bank ? LINE_ADDRESS_WIDTH'(H_PIXELS) : {LINE_ADDRESS_WIDTH{1'b0}};

    assign busy               = (state == FILL);
    assign fb_read_address    = issue ? (src_addr + FB_ADDRESS_WIDTH'(issue_cnt)) : {FB_ADDRESS_WIDTH{1'b0}};
    assign line_write_enable  = wr_fire;
    assign line_write_data    = wr_fire ? fb_read_data : {PIXEL_WIDTH{1'b0}};
    assign line_write_address = wr_fire ? (wr_base + LINE_ADDRESS_WIDTH'(pipe_idx[READ_LATENCY-1]))
                                        : {LINE_ADDRESS_WIDTH{1'b0}};

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            src_addr     <= '0;
            src_line     <= '0;
            issue_cnt    <= '0;
            write_bank   <= 1'b0;
            bank_valid   <= 2'b00;
            repeat_cnt   <= '0;
            pipe_vld     <= '0;
            line_sync    <= '0;
            display_bank <= 1'b0;
            underrun     <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_idx[i] <= '0;
            end
        end else begin
            line_sync <= {line_sync[1:0], line_finished};
            underrun  <= 1'b0;

            // Read-return pipeline: carries each issued pixel index until its data arrives.
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            pipe_vld[0] <= issue;
            pipe_idx[0] <= issue_cnt[IDX_W-1:0];
            if (issue) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end

            if (!enable) begin
                state     <= IDLE;
                pipe_vld  <= '0;
                issue_cnt <= '0;
            end else if (frame_start) begin
                state      <= FILL;
                src_addr   <= fb_base;
                src_line   <= '0;
                write_bank <= 1'b0;
                display_bank <= 1'b0;
                repeat_cnt <= '0;
                bank_valid <= 2'b00;
                issue_cnt  <= '0;
                pipe_vld   <= '0;
            end else if (state != IDLE) begin
                bank_valid <= bv_next;

                if (le_active) begin
                    if (switch_disp) begin
                        repeat_cnt   <= '0;
                        display_bank <= new_disp;
                        // A bank still mid-fill reads as invalid here; the fill simply carries on.
                        underrun     <= !bv_next[new_disp];
                    end else begin
                        repeat_cnt <= repeat_cnt + REP_W'(1);
                    end
                end

                case (state)
                    FILL: begin
                        if (fill_done) begin
                            src_addr   <= src_addr + FB_ADDRESS_WIDTH'(H_PIXELS);
                            src_line   <= src_line + LINE_W'(1);
                            write_bank <= ~write_bank;
                            issue_cnt  <= '0;
                            if (src_line + LINE_W'(1) == LINE_W'(SRC_LINES)) begin
                                state <= DONE;
                            end else if (!bv_next[~write_bank]) begin
                                state <= FILL;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (!bv_next[write_bank] && (src_line < LINE_W'(SRC_LINES))) begin
                            state <= FILL;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
